acia_tx_fifo: RTL

Parametrised next-generation serial transmitter for the ACIA.
- Adds a TX FIFO, a runtime-programmable baud divisor, runtime frame format (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and a TX-complete pulse.
- Sits between the CPU bus register decode and the tx pin, alongside the existing receive path.

---
 rtl/acia_tx_fifo_if.sv | 22 ++
 rtl/acia_tx_fifo.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/acia_tx_fifo_if.sv
// CPU-side write port of the ACIA transmitter: byte write strobe plus FIFO status.
// master = bus register decode, slave = transmitter.
interface acia_tx_fifo_if #(
   parameter int unsigned FIFO_AW = 4
);
   logic [7:0]       tx_dat;
   logic             tx_wr;
   logic             tx_full;
   logic             tx_empty;
   logic [FIFO_AW:0] tx_level;
   logic             tx_ovf;

   modport master (
      output tx_dat, tx_wr,
      input  tx_full, tx_empty, tx_level, tx_ovf
   );

   modport slave (
      input  tx_dat, tx_wr,
      output tx_full, tx_empty, tx_level, tx_ovf
   );
endinterface

// File: rtl/acia_tx_fifo.sv
// ACIA serial transmitter with TX FIFO, runtime baud divisor and frame format
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and a TX-complete pulse.
// Optional macro ACIA_TX_BREAK_EN adds i_tx_break: holds the idle line low (break).
module acia_tx_fifo #(
   parameter int unsigned SCW     = 16,
   parameter int unsigned FIFO_AW = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [SCW-1:0]   i_baud_div,
   input  logic [1:0]       i_cfg_dbits,
   input  logic [1:0]       i_cfg_par,
   input  logic             i_cfg_stop2,
`ifdef ACIA_TX_BREAK_EN
   input  logic             i_tx_break,
`endif
   acia_tx_fifo_if.slave    io_bus,
   output logic             o_tx_busy,
   output logic             o_tx_done,
   output logic             o_tx_serial
);
   localparam int unsigned DEPTH = 2 ** FIFO_AW;

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   // FIFO storage and status
   logic [7:0]         r_mem [DEPTH];
   logic [FIFO_AW-1:0] r_wptr, r_rptr;
   logic [FIFO_AW:0]   r_level;
   logic               r_full, r_empty, r_ovf;

   // Frame engine
   state_e             r_state;
   logic [SCW-1:0]     r_cnt, r_div;
   logic [7:0]         r_shift;
   logic [2:0]         r_bitidx, r_lastidx;
   logic               r_par_en, r_par_bit, r_stop2, r_stop_left;
   logic               r_hold, r_serial, r_done, r_busy;

   logic               w_push, w_pop, w_break, w_bit_end, w_frame_end, w_par_bit;
   logic [FIFO_AW:0]   w_level_d;
   logic [7:0]         w_head, w_mask;

`ifdef ACIA_TX_BREAK_EN
   assign w_break = i_tx_break;
`else
   assign w_break = 1'b0;
`endif

   assign w_push      = io_bus.tx_wr & ~r_full;
   assign w_bit_end   = (r_cnt == '0);
   assign w_frame_end = (r_state == StStop) & w_bit_end & ~r_stop_left;
   // A new frame starts from idle, or straight out of the last stop bit with no gap.
   assign w_pop       = ~r_empty & ~w_break & ~r_hold & ((r_state == StIdle) | w_frame_end);
   assign w_level_d   = r_level + {{FIFO_AW{1'b0}}, w_push} - {{FIFO_AW{1'b0}}, w_pop};

   assign w_head    = r_mem[r_rptr];
   assign w_mask    = 8'hFF >> (3'd3 - {1'b0, i_cfg_dbits});
   // Even parity = XOR of the bits actually sent; odd (cfg 2) inverts it.
   assign w_par_bit = (^(w_head & w_mask)) ^ (i_cfg_par == 2'd2);

   // FIFO storage write; contents are not reset, the pointers define validity
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wptr] <= io_bus.tx_dat;
   end

   // FIFO pointers, occupancy and status flags
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
         r_ovf   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + FIFO_AW'(1);
         if (w_pop)  r_rptr <= r_rptr + FIFO_AW'(1);
         r_level <= w_level_d;
         r_full  <= w_level_d[FIFO_AW];
         r_empty <= (w_level_d == '0);
         r_ovf   <= io_bus.tx_wr & r_full;
      end
   end

   // Frame FSM with registered line, done and busy outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_div       <= '0;
         r_shift     <= '0;
         r_bitidx    <= '0;
         r_lastidx   <= '0;
         r_par_en    <= 1'b0;
         r_par_bit   <= 1'b0;
         r_stop2     <= 1'b0;
         r_stop_left <= 1'b0;
         r_hold      <= 1'b0;
         r_serial    <= 1'b1;
         r_done      <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_busy <= 1'b1;
         if (w_pop) begin
            // Frame settings are latched here so mid-frame config writes wait a frame.
            r_state   <= StStart;
            r_serial  <= 1'b0;
            r_cnt     <= i_baud_div;
            r_div     <= i_baud_div;
            r_shift   <= w_head;
            r_bitidx  <= '0;
            r_lastidx <= 3'd4 + {1'b0, i_cfg_dbits};
            r_par_en  <= ^i_cfg_par;
            r_par_bit <= w_par_bit;
            r_stop2   <= i_cfg_stop2;
            if (w_frame_end) r_done <= 1'b1;
         end else begin
            unique case (r_state)
               StIdle: begin
                  r_busy <= (w_level_d != '0);
                  if (w_break) begin
                     // Preload one bit period so the line stays high that long after release.
                     r_serial <= 1'b0;
                     r_hold   <= 1'b1;
                     r_cnt    <= i_baud_div;
                  end else begin
                     r_serial <= 1'b1;
                     if (r_hold) begin
                        if (w_bit_end) r_hold <= 1'b0;
                        else           r_cnt  <= r_cnt - SCW'(1);
                     end
                  end
               end
               StStart: begin
                  if (w_bit_end) begin
                     r_state  <= StData;
                     r_serial <= r_shift[0];
                     r_shift  <= r_shift >> 1;
                     r_cnt    <= r_div;
                  end else begin
                     r_cnt <= r_cnt - SCW'(1);
                  end
               end
               StData: begin
                  if (w_bit_end) begin
                     r_cnt <= r_div;
                     if (r_bitidx == r_lastidx) begin
                        if (r_par_en) begin
                           r_state  <= StParity;
                           r_serial <= r_par_bit;
                        end else begin
                           r_state     <= StStop;
                           r_serial    <= 1'b1;
                           r_stop_left <= r_stop2;
                        end
                     end else begin
                        r_serial <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                        r_bitidx <= r_bitidx + 3'd1;
                     end
                  end else begin
                     r_cnt <= r_cnt - SCW'(1);
                  end
               end
               StParity: begin
                  if (w_bit_end) begin
                     r_state     <= StStop;
                     r_serial    <= 1'b1;
                     r_stop_left <= r_stop2;
                     r_cnt       <= r_div;
                  end else begin
                     r_cnt <= r_cnt - SCW'(1);
                  end
               end
               StStop: begin
                  if (w_bit_end) begin
                     if (r_stop_left) begin
                        r_stop_left <= 1'b0;
                        r_cnt       <= r_div;
                     end else begin
                        r_state  <= StIdle;
                        r_serial <= 1'b1;
                        r_done   <= 1'b1;
                        r_busy   <= (w_level_d != '0);
                     end
                  end else begin
                     r_cnt <= r_cnt - SCW'(1);
                  end
               end
               default: begin
                  r_state  <= StIdle;
                  r_serial <= 1'b1;
               end
            endcase
         end
      end
   end

   assign io_bus.tx_full  = r_full;
   assign io_bus.tx_empty = r_empty;
   assign io_bus.tx_level = r_level;
   assign io_bus.tx_ovf   = r_ovf;
   assign o_tx_busy       = r_busy;
   assign o_tx_done       = r_done;
   assign o_tx_serial     = r_serial;
endmodule
